// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Computes {cout,sum} = a + b + cin, one bit per clock, LSB first.
// It reuses a single full_adder cell for every bit.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, cin)
//   out_valid/out_ready  result handshake (sum, cout)
//   busy                 high while bits are being added
//
// state | meaning
// IDLE  | ready for operands; last result still visible on sum/cout
// RUN   | one bit per edge through the full adder, WIDTH edges total
// DONE  | result valid; held until out_ready

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_sum, fa_co;
  logic [WIDTH:0]   sum_shift;

  full_adder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .ci  (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  // The new bit enters at the MSB. Slicing the concatenation keeps WIDTH=1 legal.
  assign sum_shift = {fa_sum, sum_sr_q};

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        sum_sr_d = sum_shift[WIDTH:1];
        carry_d  = fa_co;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sum  = sum_sr_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] a, b, sum;
  logic       cin, cout;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [0:0] a1, b1, sum1;
  logic       cin1, cout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the controller idle. Returns at the first negedge with out_valid.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     output logic [7:0] s_o, output logic co_o,
                     output int lat, output int busy_n);
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    @(negedge clk);
    in_valid = 1'b0; a = ~av; b = ~bv; cin = ~cv;
    lat = 0; busy_n = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    s_o = sum; co_o = cout;
  endtask

  logic [7:0] s, s0;
  logic       co, c0;
  int         lat, bn;
  logic [8:0] exp9;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_carry_q", dut.carry_q, 0);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, bn);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy_cycles", i), bn, 8);
      check($sformatf("vec%0d_sum", i), s, vecs[i].s);
      check($sformatf("vec%0d_cout", i), co, vecs[i].co);
      check($sformatf("vec%0d_in_ready_done", i), in_ready, 0);
      @(negedge clk);
      check($sformatf("vec%0d_retired", i), out_valid, 0);
      check($sformatf("vec%0d_idle_ready", i), in_ready, 1);
      check($sformatf("vec%0d_sum_held_idle", i), sum, vecs[i].s);
    end

    // Backpressure with new operands pending
    out_ready = 1'b0;
    op8(8'h5A, 8'h3C, 1'b0, s0, c0, lat, bn);
    check("bp_sum_initial", s0, 8'h96);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum_stable", sum, 8'h96);
      check("bp_cout_stable", cout, 0);
    end
    a = 8'h21; b = 8'h43; cin = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_retire_idle", in_ready, 1);
    check("bp_retire_ov", out_valid, 0);
    @(negedge clk);
    check("bp_accept_busy", busy, 1);
    in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("bp_next_latency", lat, 8);
    check("bp_next_sum", sum, 8'h65);
    check("bp_next_cout", cout, 0);
    @(negedge clk);

    // Asynchronous reset after 3 bit-cycles
    in_valid = 1'b1; a = 8'h77; b = 8'h11; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_sum", sum, 0);
    check("async_rst_carry_q", dut.carry_q, 0);
    repeat (2) @(negedge clk);
    check("in_rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_carry_q", dut.carry_q, 0);
    op8(8'h12, 8'h34, 1'b0, s, co, lat, bn);
    check("post_rst_latency", lat, 8);
    check("post_rst_sum", s, 8'h46);
    check("post_rst_cout", co, 0);
    @(negedge clk);

    // Random operations
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      op8(ra, rb, rc, s, co, lat, bn);
      check($sformatf("rand%0d_result", i), {23'd0, co, s}, {23'd0, exp9});
      check($sformatf("rand%0d_latency", i), lat, 8);
      @(negedge clk);
    end

    // WIDTH=1 instance, all combinations
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int e;
      v = 3'(i);
      e = int'(v[2]) + int'(v[1]) + int'(v[0]);
      check($sformatf("w1_%0d_ready", i), in_ready1, 1);
      in_valid1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(negedge clk);
      in_valid1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
      check($sformatf("w1_%0d_busy", i), busy1, 1);
      lat = 0;
      while (!out_valid1 && lat < 10) begin @(negedge clk); lat++; end
      check($sformatf("w1_%0d_latency", i), lat, 1);
      check($sformatf("w1_%0d_result", i), {30'd0, cout1, sum1}, 32'(e));
      @(negedge clk);
      check($sformatf("w1_%0d_retired", i), out_valid1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It time-shares one instance of the team's full_adder cell (ports a, b, ci, sum, co) to add two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first. It sequences the cell with operand shift registers, a carry flop, a bit counter and a 3-state FSM. Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  sum and cout are valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  registered result, A+B+cin mod 2^WIDTH
cout  output  1  registered carry-out of the full sum
busy  output  1  high while in RUN

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, all shift registers, carry flop and counter = 0. Outputs: in_ready=1, out_valid=0, sum=0, cout=0, busy=0. Deassertion is sampled at clk.
- Internal state: a_sr, b_sr (WIDTH bits each), carry_q (1 bit), cnt (max(1,$clog2(WIDTH)) bits), sum_sr (WIDTH bits), which drives the sum output.
- full_adder connections: a=a_sr[0], b=b_sr[0], ci=carry_q. The outputs feed sum_sr and carry_q. No other adder logic is allowed in the block.
- IDLE: in_ready=1, busy=0.
  - On in_valid at an edge: a_sr<=a, b_sr<=b, carry_q<=cin, cnt<=0, sum_sr<=0; go to RUN.
  - Without in_valid: hold all state.
- RUN: in_ready=0, busy=1. Each edge:
  - sum_sr <= {fa.sum, sum_sr[WIDTH-1:1]}, i.e. shift right with the new bit entering at the MSB.
  - carry_q <= fa.co.
  - a_sr and b_sr shift right by 1, zero-filled.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: cout<=fa.co and go to DONE; cnt is not incremented past WIDTH-1.
- DONE: out_valid=1, in_ready=0, busy=0. sum and cout are held stable until out_ready=1 at an edge, which returns the FSM to IDLE.
  - sum and cout keep their values in IDLE until the next operand acceptance, where sum clears to 0.
- Latency: operands accepted at edge t gives out_valid=1 after edge t+WIDTH. Throughput is at most one operation per WIDTH+2 cycles.
- Handshake rules:
  - in_valid is ignored in RUN and DONE.
  - Changes on a and b after acceptance have no effect.
  - out_valid never drops without out_ready.
  - A new acceptance is impossible in the same cycle as result retirement, because in_ready=0 in DONE. The earliest next acceptance is the edge after retirement.
- WIDTH=1: RUN lasts exactly one edge and cnt is a 1-bit constant-0 compare.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse occurs.
- Unreachable state encoding: recover to IDLE.
- Arithmetic: {cout,sum} == a+b+cin computed at WIDTH+1 bits, exact with no truncation.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid exactly 8 edges after acceptance, sum=0x96, cout=0; busy high for 8 cycles.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0, b=0, cin=1 -> sum=0x01, cout=0.
3. Backpressure: out_ready=0 for 5 cycles after out_valid, with in_valid held high and new operands toggling -> sum and cout stable, in_ready=0. Drive out_ready=1 -> IDLE; the new operands are accepted the following edge.
4. Assert rst_n=0 asynchronously mid-RUN (after 3 bit-cycles) -> outputs go to reset values immediately with no clk edge, no out_valid. After release, 0x12+0x34 -> 0x46, cout=0.
5. Randomised check of 200 operations, each comparing {cout,sum} against a+b+cin. Also check the probe dut.carry_q == 0 in IDLE after reset.
6. WIDTH=1 instance: all 8 (a,b,cin) combinations -> {cout,sum}=a+b+cin, out_valid one edge after acceptance.
